// File: rtl/wdt_slave.sv
// Watchdog timer with a rib bus slave port: count down from LOAD, raise a
// warning interrupt on the first expiry, and request a SoC reset on the second.
module wdt_slave #(
  parameter int unsigned BITE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        int_sig_o,
  output logic        rst_req_o
);

  localparam int unsigned BW = (BITE_CYCLES > 1) ? $clog2(BITE_CYCLES) : 1;
  localparam logic [BW-1:0] BITE_LAST = BW'(BITE_CYCLES - 1);
  localparam logic [31:0] KICK_KEY = 32'h5A5A_5A5A;

  typedef enum logic [1:0] {IDLE, RUN, WARN, BITE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   load_q, load_d;
  logic          en_q, en_d;
  logic          inten_q, inten_d;
  logic          rsten_q, rsten_d;
  logic          pend_q, pend_d;
  logic          lock_q, lock_d;
  logic [BW-1:0] bite_q, bite_d;

  logic [1:0] sel;
  logic       wr, ctrlWr, ctrlOpen, loadWr, kickWr;

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

  assign sel      = addr_i[3:2];
  assign wr       = req_i & we_i;
  assign ctrlWr   = wr && (sel == 2'd0);
  assign ctrlOpen = ctrlWr && !lock_q;
  assign loadWr   = wr && (sel == 2'd1) && !lock_q;
  assign kickWr   = wr && (sel == 2'd3) && (data_i == KICK_KEY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 32'hFFFF_FFFF;
      load_q  <= 32'hFFFF_FFFF;
      en_q    <= 1'b0;
      inten_q <= 1'b0;
      rsten_q <= 1'b0;
      pend_q  <= 1'b0;
      lock_q  <= 1'b0;
      bite_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      load_q  <= load_d;
      en_q    <= en_d;
      inten_q <= inten_d;
      rsten_q <= rsten_d;
      pend_q  <= pend_d;
      lock_q  <= lock_d;
      bite_q  <= bite_d;
    end
  end

  // PEND clear is applied before the FSM so that a same-cycle expiry set wins.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load_d  = load_q;
    en_d    = en_q;
    inten_d = inten_q;
    rsten_d = rsten_q;
    pend_d  = pend_q;
    lock_d  = lock_q;
    bite_d  = bite_q;

    if (loadWr) load_d = data_i;
    if (ctrlOpen) begin
      inten_d = data_i[1];
      rsten_d = data_i[2];
      lock_d  = data_i[4];
    end
    if (ctrlWr && data_i[3]) pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrlOpen && data_i[0]) begin
          state_d = RUN;
          en_d    = 1'b1;
          count_d = load_q;
        end
      end
      RUN, WARN: begin
        if (ctrlOpen && !data_i[0]) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (kickWr) begin
          count_d = load_q;
        end else if (count_q == 32'd0) begin
          if (state_q == RUN) begin
            state_d = WARN;
            pend_d  = 1'b1;
            count_d = load_q;
          end else if (rsten_q) begin
            state_d = BITE;
            bite_d  = '0;
          end else begin
            count_d = load_q;
          end
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      BITE: begin
        if (bite_q == BITE_LAST) begin
          state_d = IDLE;
          en_d    = 1'b0;
          count_d = load_q;
        end else begin
          bite_d = bite_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_o = 32'd0;
    if (req_i && !we_i) begin
      case (sel)
        2'd0:    data_o = {27'd0, lock_q, pend_q, rsten_q, inten_q, en_q};
        2'd1:    data_o = load_q;
        2'd2:    data_o = count_q;
        default: data_o = 32'd0;
      endcase
    end
  end

  assign ack_o     = req_i;
  assign int_sig_o = pend_q & inten_q;
  assign rst_req_o = (state_q == BITE);

endmodule

// File: tb/tb_wdt_slave.sv
// Self-checking bench for wdt_slave: register reads go through a scoreboard
// queue whose entries are popped when the DUT acknowledges the access.
module tb_wdt_slave;

  localparam logic [31:0] A_CTRL  = 32'h0;
  localparam logic [31:0] A_LOAD  = 32'h4;
  localparam logic [31:0] A_COUNT = 32'h8;
  localparam logic [31:0] A_KICK  = 32'hC;

  logic        clk, rst, req_i, we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        ack_o, int_sig_o, rst_req_o;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sbItem_t;

  sbItem_t sbQ[$];
  int testsRun = 0;
  int failCount = 0;

  wdt_slave #(.BITE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .ack_o(ack_o),
    .int_sig_o(int_sig_o), .rst_req_o(rst_req_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    req_i = 1'b1; we_i = 1'b1; addr_i = addr; data_i = data;
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = 1'b0; data_i = 32'd0;
  endtask

  task automatic readReg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    sbItem_t item;
    sbQ.push_back('{tag: tag, val: exp});
    req_i = 1'b1; we_i = 1'b0; addr_i = addr;
    #1;
    checkOutput({tag, "_ack"}, {31'd0, ack_o}, 32'd1);
    if (sbQ.size() > 0) begin
      item = sbQ.pop_front();
      checkOutput(item.tag, data_o, item.val);
    end
    req_i = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int firstHi;
    int hiCount;
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
    tick(2);
    rst = 1'b0;

    // Reset values and basic bus behaviour
    readReg("rst_ctrl", A_CTRL, 32'h0);
    readReg("rst_load", A_LOAD, 32'hFFFF_FFFF);
    readReg("rst_count", A_COUNT, 32'hFFFF_FFFF);
    checkOutput("rst_int", {31'd0, int_sig_o}, 32'd0);
    checkOutput("rst_req", {31'd0, rst_req_o}, 32'd0);
    readReg("kick_reads0", A_KICK, 32'h0);
    addr_i = A_LOAD; req_i = 1'b0;
    #1;
    checkOutput("noreq_data", data_o, 32'h0);
    checkOutput("noreq_ack", {31'd0, ack_o}, 32'd0);
    req_i = 1'b1; we_i = 1'b1; data_i = 32'h1234;
    #1;
    checkOutput("wr_data0", data_o, 32'h0);
    req_i = 1'b0; we_i = 1'b0;
    applyStimulus(A_COUNT, 32'd123);
    readReg("count_ro", A_COUNT, 32'hFFFF_FFFF);

    // Basic expiry: PEND exactly 11 cycles after the enabling edge
    doReset();
    applyStimulus(A_LOAD, 32'd10);
    applyStimulus(A_CTRL, 32'h3);
    tick(10);
    checkOutput("exp_int_early", {31'd0, int_sig_o}, 32'd0);
    tick(1);
    checkOutput("exp_int", {31'd0, int_sig_o}, 32'd1);
    readReg("exp_ctrl", A_CTRL, 32'h0B);
    readReg("exp_count", A_COUNT, 32'd10);

    // Bite: four cycles of rst_req_o starting 12 cycles after enable
    doReset();
    applyStimulus(A_LOAD, 32'd5);
    applyStimulus(A_CTRL, 32'h7);
    firstHi = -1;
    hiCount = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (rst_req_o) begin
        if (firstHi < 0) firstHi = c;
        hiCount++;
      end
    end
    checkOutput("bite_start", 32'(firstHi), 32'd12);
    checkOutput("bite_len", 32'(hiCount), 32'd4);
    readReg("bite_ctrl", A_CTRL, 32'h0E);
    readReg("bite_count", A_COUNT, 32'd5);
    tick(3);
    readReg("bite_idle", A_COUNT, 32'd5);

    // Kicking keeps PEND clear; a wrong key does not reload
    doReset();
    applyStimulus(A_LOAD, 32'd8);
    applyStimulus(A_CTRL, 32'h3);
    repeat (17) begin
      tick(5);
      applyStimulus(A_KICK, 32'h5A5A_5A5A);
    end
    readReg("kick_ctrl", A_CTRL, 32'h03);
    readReg("kick_count", A_COUNT, 32'd8);
    applyStimulus(A_KICK, 32'h1234_5678);
    readReg("badkick_count", A_COUNT, 32'd7);
    tick(7);
    checkOutput("badkick_int0", {31'd0, int_sig_o}, 32'd0);
    tick(1);
    checkOutput("badkick_int1", {31'd0, int_sig_o}, 32'd1);

    // Collisions: kick vs expiry, then PEND clear vs PEND set
    doReset();
    applyStimulus(A_LOAD, 32'd4);
    applyStimulus(A_CTRL, 32'h3);
    tick(4);
    applyStimulus(A_KICK, 32'h5A5A_5A5A);
    readReg("col_kick_ctrl", A_CTRL, 32'h03);
    readReg("col_kick_count", A_COUNT, 32'd4);
    tick(4);
    applyStimulus(A_CTRL, 32'h0B);
    readReg("col_clr_ctrl", A_CTRL, 32'h0B);
    checkOutput("col_clr_int", {31'd0, int_sig_o}, 32'd1);
    applyStimulus(A_CTRL, 32'h0B);
    readReg("clr_ctrl", A_CTRL, 32'h03);

    // Lock blocks CTRL/LOAD writes but not PEND clear
    doReset();
    applyStimulus(A_LOAD, 32'd20);
    applyStimulus(A_CTRL, 32'h17);
    applyStimulus(A_LOAD, 32'd3);
    applyStimulus(A_CTRL, 32'h0);
    readReg("lock_load", A_LOAD, 32'd20);
    readReg("lock_ctrl", A_CTRL, 32'h17);
    tick(19);
    readReg("lock_pend", A_CTRL, 32'h1F);
    applyStimulus(A_CTRL, 32'h08);
    readReg("lock_clr", A_CTRL, 32'h17);
    checkOutput("lock_int", {31'd0, int_sig_o}, 32'd0);

    // LOAD=0 expires on the cycle after reload and never wraps
    doReset();
    applyStimulus(A_LOAD, 32'd0);
    applyStimulus(A_CTRL, 32'h3);
    readReg("zero_ctrl0", A_CTRL, 32'h03);
    tick(1);
    readReg("zero_ctrl1", A_CTRL, 32'h0B);
    tick(3);
    readReg("zero_count", A_COUNT, 32'd0);

    // Reset during the second BITE cycle
    doReset();
    applyStimulus(A_LOAD, 32'd2);
    applyStimulus(A_CTRL, 32'h7);
    tick(7);
    checkOutput("midbite_req1", {31'd0, rst_req_o}, 32'd1);
    doReset();
    checkOutput("midbite_req0", {31'd0, rst_req_o}, 32'd0);
    readReg("midbite_ctrl", A_CTRL, 32'h0);
    readReg("midbite_load", A_LOAD, 32'hFFFF_FFFF);
    checkOutput("midbite_int", {31'd0, int_sig_o}, 32'd0);
    tick(5);
    checkOutput("midbite_stay", {31'd0, rst_req_o}, 32'd0);
    readReg("midbite_count", A_COUNT, 32'hFFFF_FFFF);

    checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/wdt_slave.md
WDT_SLAVE -- requirements
Module: wdt_slave

Interface
REQ-001 SHALL have parameter BITE_CYCLES, default 4, giving the number of cycles rst_req_o is held high.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-004 SHALL have port req_i, input, 1, the bus access request from the rib slave port.
REQ-005 SHALL have port we_i, input, 1, the bus write enable (1 = write).
REQ-006 SHALL have port addr_i, input, 32, the bus address; only addr_i[3:2] is decoded.
REQ-007 SHALL have port data_i, input, 32, the bus write data.
REQ-008 SHALL have port data_o, output, 32, the bus read data.
REQ-009 SHALL have port ack_o, output, 1, the bus acknowledge.
REQ-010 SHALL have port int_sig_o, output, 1, the watchdog warning interrupt, routed into int_flag.
REQ-011 SHALL have port rst_req_o, output, 1, the bite reset request to the SoC reset logic.

Function
REQ-012 SHALL decode these registers on addr_i[3:2]:
- 0 = CTRL: bit0 EN, bit1 INT_EN, bit2 RST_EN, bit3 PEND (read; write 1 clears), bit4 LOCK (set-only).
- 1 = LOAD: 32-bit reload value, read/write.
- 2 = COUNT: current count, read-only.
- 3 = KICK: write-only, reads 0.
REQ-013 SHALL drive ack_o = req_i combinationally; reads return data combinationally in the same cycle; writes take effect at the next clock edge.
REQ-014 SHALL return 0 on data_o when req_i=0 or we_i=1.
REQ-015 SHALL implement state machine IDLE, RUN, WARN, BITE.
- IDLE -> RUN when EN is written 1; COUNT <= LOAD.
- RUN: COUNT decrements by 1 per cycle; at COUNT==0, go to WARN, set PEND, COUNT <= LOAD.
- WARN: COUNT decrements; at COUNT==0, go to BITE if RST_EN=1, else stay in WARN with COUNT <= LOAD.
- BITE: rst_req_o=1 for exactly BITE_CYCLES cycles, then go to IDLE, EN <= 0, COUNT <= LOAD.
REQ-016 SHALL treat a KICK write of data 32'h5A5A_5A5A in RUN or WARN as a reload, COUNT <= LOAD, with no state change and PEND unchanged; any other data SHALL be ignored.
REQ-017 SHALL give a kick priority over expiry when both occur in the same cycle.
REQ-018 SHALL give set priority when a PEND write-1-clear and a new PEND set occur in the same cycle.
REQ-019 SHALL return to IDLE on an EN=0 write in RUN or WARN, with COUNT held; EN writes SHALL be ignored during BITE.
REQ-020 SHALL ignore, once LOCK=1, writes to CTRL bits 0-2, to LOCK, and to LOAD until rst; PEND clear and KICK SHALL remain functional.
REQ-021 SHALL treat LOAD=0 as expiry on the cycle after the reload; COUNT SHALL never wrap below 0.
REQ-022 SHALL drive int_sig_o = PEND & INT_EN, registered-state only (no combinational path from bus inputs).
REQ-023 SHALL ignore bus writes to COUNT.

Reset
REQ-024 SHALL, while rst=1:
- State = IDLE.
- CTRL = 0, LOAD = 32'hFFFF_FFFF, COUNT = 32'hFFFF_FFFF.
- int_sig_o = 0, rst_req_o = 0, BITE counter cleared.
REQ-025 SHALL, when rst is asserted mid-BITE, deassert rst_req_o on the next edge.

Verification
REQ-026 SHALL cover basic expiry: LOAD=10, CTRL=0x3 -> PEND=1 and int_sig_o=1 exactly 11 cycles after the write edge; COUNT reads 10.
REQ-027 SHALL cover bite: LOAD=5, CTRL=0x7, no kicks -> rst_req_o high for 4 cycles starting 12 cycles after enable; then EN=0 and state IDLE.
REQ-028 SHALL cover kicking: LOAD=8, enable, KICK 0x5A5A5A5A every 6 cycles -> PEND stays 0 for 100 cycles; KICK 0x12345678 does not reload.
REQ-029 SHALL cover collisions: a kick in the expiry cycle -> no PEND; a PEND clear in the expiry cycle -> PEND reads 1.
REQ-030 SHALL cover lock: CTRL=0x17, then write LOAD=3 and CTRL=0 -> LOAD unchanged, EN still 1; a PEND clear still works.
REQ-031 SHALL cover reset mid-BITE: rst pulse in BITE cycle 2 -> rst_req_o=0 next cycle, all registers at reset values.
